// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate register: parallel load plus a start/busy/done command
// that shifts, rotates or serially fills the register one bit position per clock.
module shift_rotate_unit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clock_i,
    input  logic             resetn_i,
    input  logic             loadn_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             start_i,
    input  logic [2:0]       mode_i,
    input  logic [AMT_W-1:0] amount_i,
    input  logic             serial_in_i,
    output logic [WIDTH-1:0] q_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             serial_out_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_LSR = 3'd1;
    localparam logic [2:0] M_ASR = 3'd2;
    localparam logic [2:0] M_ROL = 3'd3;
    localparam logic [2:0] M_ROR = 3'd4;
    localparam logic [2:0] M_SSL = 3'd5;
    localparam logic [2:0] M_SSR = 3'd6;
    localparam logic [2:0] M_RSV = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             sout_q, sout_d;

    logic [WIDTH-1:0] step_q;
    logic             step_out;

    // One single-position step of the latched operation; bit leaving goes to step_out.
    always_comb begin
        step_q   = q_q;
        step_out = sout_q;
        case (mode_q)
            M_LSL:   {step_out, step_q} = {q_q, 1'b0};
            M_LSR:   {step_q, step_out} = {1'b0, q_q};
            M_ASR:   {step_q, step_out} = {q_q[WIDTH-1], q_q};
            M_ROL:   {step_out, step_q} = {q_q, q_q[WIDTH-1]};
            M_ROR:   {step_q, step_out} = {q_q[0], q_q};
            M_SSL:   {step_out, step_q} = {q_q, serial_in_i};
            M_SSR:   {step_q, step_out} = {serial_in_i, q_q};
            default: begin
                step_q   = q_q;
                step_out = sout_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        sout_d  = sout_q;
        case (state_q)
            ST_IDLE: begin
                if (!loadn_i) begin
                    q_d = data_in_i;
                end else if (start_i) begin
                    mode_d = mode_i;
                    cnt_d  = amount_i;
                    if (amount_i == '0 || mode_i == M_RSV) state_d = ST_DONE;
                    else                                   state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                q_d    = step_q;
                sout_d = step_out;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            sout_q  <= sout_d;
        end
    end

    assign q_o          = q_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign serial_out_o = sout_q;
endmodule

// File: tb/tb_shift_rotate_unit.sv
// Bench for shift_rotate_unit: directed vector table, busy-protection and mid-run
// reset sequences, then random commands against an arithmetic reference model.
module tb_shift_rotate_unit;
    localparam int W   = 8;
    localparam int AW  = 4;
    localparam int MOD = 1 << W;
    localparam int HALF = MOD / 2;

    logic          clock, resetn, loadn, start, serial_in;
    logic [W-1:0]  data_in;
    logic [2:0]    mode;
    logic [AW-1:0] amount;
    logic [W-1:0]  q;
    logic          busy, done, serial_out;

    int n_chk = 0;
    int n_fail = 0;
    int mq = 0;   // model register value
    int mso = 0;  // model serial_out

    shift_rotate_unit #(.WIDTH(W), .AMT_W(AW)) dut (
        .clock_i(clock), .resetn_i(resetn), .loadn_i(loadn), .data_in_i(data_in),
        .start_i(start), .mode_i(mode), .amount_i(amount), .serial_in_i(serial_in),
        .q_o(q), .busy_o(busy), .done_o(done), .serial_out_o(serial_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  ld;
        logic [2:0]  md;
        logic [3:0]  amt;
        logic [15:0] sin;
        logic [7:0]  exp_q;
        logic        exp_so;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: one step computed with plain integer arithmetic.
    task automatic model_step(input int m, input int sin);
        int o;
        o = 0;
        case (m)
            0: begin o = mq / HALF; mq = (mq * 2) % MOD; end
            1: begin o = mq % 2;    mq = mq / 2; end
            2: begin o = mq % 2;    mq = mq / 2 + ((mq >= HALF) ? HALF : 0); end
            3: begin o = mq / HALF; mq = (mq * 2) % MOD + o; end
            4: begin o = mq % 2;    mq = mq / 2 + o * HALF; end
            5: begin o = mq / HALF; mq = (mq * 2) % MOD + sin; end
            6: begin o = mq % 2;    mq = mq / 2 + sin * HALF; end
            default: o = mso;
        endcase
        mso = o;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        @(negedge clock);
        loadn = 1'b0; data_in = v;
        @(negedge clock);
        loadn = 1'b1;
        mq = int'(v);
        check("load_q", q, v);
    endtask

    // Issue one command, follow it to done, and compare latency, busy, q, serial_out.
    task automatic run_cmd(input logic [2:0] m, input logic [AW-1:0] a,
                           input logic [15:0] sin, input bit hostile);
        int cyc, busy_low, exp_lat, nsteps;
        @(negedge clock);
        loadn = 1'b1; start = 1'b1; mode = m; amount = a;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        busy_low = 0;
        nsteps = (a == 0 || m == 3'd7) ? 0 : int'(a);
        exp_lat = nsteps + 1;
        for (int i = 0; i < nsteps; i++) model_step(int'(m), int'(sin[i]));
        while (!done && cyc < 40) begin
            if (!busy) busy_low++;
            serial_in = sin[cyc-1];
            if (hostile) begin
                loadn = 1'b0; data_in = 8'h3C; start = 1'b1;
                mode = 3'($urandom_range(0, 7)); amount = AW'($urandom);
            end
            @(negedge clock);
            cyc++;
        end
        loadn = 1'b1; start = 1'b0;
        check("done_seen", done, 1'b1);
        check("busy_at_done", busy, 1'b1);
        check("latency", cyc, exp_lat);
        check("busy_during", busy_low, 0);
        check("q_final", q, mq);
        check("serial_out", serial_out, mso);
        @(negedge clock);
        check("done_one_pulse", done, 1'b0);
        check("idle_after_done", busy, 1'b0);
        check("q_hold_idle", q, mq);
    endtask

    vec_t vt[10];

    initial begin
        resetn = 1'b0; loadn = 1'b1; start = 1'b0; serial_in = 1'b0;
        data_in = '0; mode = '0; amount = '0;

        vt[0] = '{8'hA5, 3'd2, 4'd3,  16'h0000, 8'hF4, 1'b1};
        vt[1] = '{8'h81, 3'd0, 4'd2,  16'h0000, 8'h04, 1'b0};
        vt[2] = '{8'h5A, 3'd0, 4'd0,  16'h0000, 8'h5A, 1'b0};
        vt[3] = '{8'h01, 3'd4, 4'd9,  16'h0000, 8'h80, 1'b1};
        vt[4] = '{8'hFF, 3'd1, 4'd15, 16'h0000, 8'h00, 1'b0};
        vt[5] = '{8'h00, 3'd6, 4'd4,  16'h000D, 8'hD0, 1'b0};
        vt[6] = '{8'h3C, 3'd7, 4'd5,  16'h0000, 8'h3C, 1'b0};
        vt[7] = '{8'h81, 3'd3, 4'd3,  16'h0000, 8'h0C, 1'b0};
        vt[8] = '{8'h00, 3'd5, 4'd3,  16'h0003, 8'h06, 1'b0};
        vt[9] = '{8'h80, 3'd2, 4'd12, 16'h0000, 8'hFF, 1'b1};

        repeat (2) @(negedge clock);
        check("rst_q", q, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_so", serial_out, 1'b0);
        resetn = 1'b1;
        mq = 0; mso = 0;

        for (int i = 0; i < 10; i++) begin
            do_load(vt[i].ld);
            run_cmd(vt[i].md, vt[i].amt, vt[i].sin, 1'b0);
            check($sformatf("vec%0d_q", i), q, vt[i].exp_q);
            check($sformatf("vec%0d_so", i), serial_out, vt[i].exp_so);
        end

        // Load/start during RUN and DONE must not disturb the running command.
        do_load(8'h96);
        run_cmd(3'd4, 4'd5, 16'h0000, 1'b1);
        check("hostile_q", q, 8'hB4);

        // Reset mid-RUN discards the command.
        do_load(8'hFF);
        @(negedge clock);
        start = 1'b1; mode = 3'd0; amount = 4'd6;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("midrun_busy", busy, 1'b1);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        mq = 0; mso = 0;
        check("midrst_q", q, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_so", serial_out, 1'b0);
        do_load(8'hC3);
        run_cmd(3'd3, 4'd2, 16'h0000, 1'b0);
        check("post_rst_q", q, 8'h0F);

        for (int i = 0; i < 40; i++) begin
            do_load(W'($urandom));
            run_cmd(3'($urandom_range(0, 7)), AW'($urandom), 16'($urandom), i[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
